// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: round-robin two-master arbiter for the IDE/CDDA/SD-card SRAM windows
`timescale 1ns/1ps
module sram_bus_arbiter #(
    parameter int SETUP_CYCLES = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic [15:0] m0_a,
    input  logic [15:0] m1_a,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [7:0]  m0_wdata,
    input  logic [7:0]  m1_wdata,
    output logic [7:0]  m0_rdata,
    output logic [7:0]  m1_rdata,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic        m0_err,
    output logic        m1_err,
    output logic [15:0] sram_a,
    output logic [7:0]  sram_d_out,
    output logic        sram_oe,
    output logic        sram_we,
    output logic        sram_cs_ide,
    output logic        sram_cs_cdda,
    output logic        sram_cs_sdcard,
    input  logic [7:0]  d_from_ide,
    input  logic [7:0]  d_from_cdda,
    input  logic [7:0]  d_from_sdcard,
    input  logic        wait_ide,
    input  logic        wait_cdda,
    input  logic        wait_sdcard,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    state_t      r_state, w_next;
    logic        r_grant, r_last, r_we, r_err;
    logic [15:0] r_a, r_cnt;
    logic [7:0]  r_wdata, r_m0_rdata, r_m1_rdata;
    logic        w_sel_ide, w_sel_cdda, w_sel_sd, w_wait, w_pick, w_setup_end, w_tmo;
    logic [7:0]  w_din;

    assign w_sel_ide   = r_a[12];
    assign w_sel_cdda  = r_a[12:11] == 2'b01;
    assign w_sel_sd    = r_a[12:11] == 2'b00;
    assign w_wait      = (w_sel_ide & wait_ide) | (w_sel_cdda & wait_cdda) | (w_sel_sd & wait_sdcard);
    assign w_din       = w_sel_ide ? d_from_ide : w_sel_cdda ? d_from_cdda : d_from_sdcard;
    assign w_pick      = (m0_req & m1_req) ? ~r_last : m1_req;
    assign w_setup_end = r_cnt == 16'(SETUP_CYCLES - 1);
    assign w_tmo       = r_cnt == 16'(TIMEOUT - 1);
    assign sram_a      = r_a;
    assign sram_d_out  = r_wdata;
    assign m0_rdata    = r_m0_rdata;
    assign m1_rdata    = r_m1_rdata;

    // State register; reset drops the bus immediately, even mid-transfer
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next state plus strobes, chip selects and completion pulses decoded from state
    always_comb begin
        w_next         = r_state;
        sram_oe        = 1'b0;
        sram_we        = 1'b0;
        sram_cs_ide    = 1'b0;
        sram_cs_cdda   = 1'b0;
        sram_cs_sdcard = 1'b0;
        m0_ack         = 1'b0;
        m1_ack         = 1'b0;
        m0_err         = 1'b0;
        m1_err         = 1'b0;
        busy           = r_state != IDLE;
        case (r_state)
            IDLE: if (m0_req | m1_req) w_next = SETUP;
            SETUP: begin
                sram_we = r_we;
                sram_oe = ~r_we;
                if (w_setup_end) w_next = ACCESS;
            end
            ACCESS: begin
                sram_we        = r_we;
                sram_oe        = ~r_we;
                sram_cs_ide    = w_sel_ide;
                sram_cs_cdda   = w_sel_cdda;
                sram_cs_sdcard = w_sel_sd;
                if (!w_wait || w_tmo) w_next = DONE;
            end
            DONE: begin
                m0_ack = ~r_grant;
                m1_ack = r_grant;
                m0_err = ~r_grant & r_err;
                m1_err = r_grant & r_err;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request latch, phase/timeout counter, read-data capture and round-robin history
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_grant    <= 1'b0;
            r_last     <= 1'b1;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_a        <= '0;
            r_cnt      <= '0;
            r_wdata    <= '0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: if (m0_req | m1_req) begin
                    r_grant <= w_pick;
                    r_a     <= w_pick ? m1_a : m0_a;
                    r_we    <= w_pick ? m1_we : m0_we;
                    r_wdata <= w_pick ? m1_wdata : m0_wdata;
                    r_cnt   <= '0;
                end
                SETUP: r_cnt <= w_setup_end ? '0 : r_cnt + 16'd1;
                ACCESS: if (!w_wait || w_tmo) begin
                    r_err <= w_wait;
                    if (r_grant) r_m1_rdata <= w_wait ? 8'hFF : w_din;
                    else         r_m0_rdata <= w_wait ? 8'hFF : w_din;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
                DONE: r_last <= r_grant;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: directed scoreboard bench for the SRAM bus arbiter
`timescale 1ns/1ps
module tb_sram_bus_arbiter;
    logic        clk = 0, reset_ = 0;
    logic        m0_req = 0, m1_req = 0, m0_we = 0, m1_we = 0;
    logic [15:0] m0_a = 0, m1_a = 0;
    logic [7:0]  m0_wdata = 0, m1_wdata = 0, m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [15:0] sram_a;
    logic [7:0]  sram_d_out;
    logic        sram_oe, sram_we, sram_cs_ide, sram_cs_cdda, sram_cs_sdcard, busy;
    logic [7:0]  d_from_ide = 0, d_from_cdda = 0, d_from_sdcard = 0;
    logic        wait_ide = 0, wait_cdda = 0, wait_sdcard = 0;

    typedef struct {
        int         port;
        logic [7:0] rd;
        logic       err;
        logic       we;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t e_m;
    int   total = 0, bad = 0, cyc = 0, n_ide = 0, n_cdda = 0, n_sd = 0;

    sram_bus_arbiter #(.SETUP_CYCLES(1), .TIMEOUT(8)) dut (
        .clk(clk), .reset_(reset_),
        .m0_req(m0_req), .m1_req(m1_req), .m0_a(m0_a), .m1_a(m1_a),
        .m0_we(m0_we), .m1_we(m1_we), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_ack(m0_ack), .m1_ack(m1_ack),
        .m0_err(m0_err), .m1_err(m1_err), .sram_a(sram_a), .sram_d_out(sram_d_out),
        .sram_oe(sram_oe), .sram_we(sram_we), .sram_cs_ide(sram_cs_ide),
        .sram_cs_cdda(sram_cs_cdda), .sram_cs_sdcard(sram_cs_sdcard),
        .d_from_ide(d_from_ide), .d_from_cdda(d_from_cdda), .d_from_sdcard(d_from_sdcard),
        .wait_ide(wait_ide), .wait_cdda(wait_cdda), .wait_sdcard(wait_sdcard), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: counts chip-select cycles, checks exclusivity, pops the scoreboard on each ack
    initial forever begin
        @(negedge clk);
        if (sram_cs_ide) n_ide++;
        if (sram_cs_cdda) n_cdda++;
        if (sram_cs_sdcard) n_sd++;
        if (sram_cs_ide | sram_cs_cdda | sram_cs_sdcard)
            chk("cs_onehot", $countones({sram_cs_ide, sram_cs_cdda, sram_cs_sdcard}), 1);
        if (m0_ack | m1_ack) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got m0=%0d m1=%0d expected none", m0_ack, m1_ack);
            end else begin
                e_m = q.pop_front();
                chk("ack_port", {30'd0, m1_ack, m0_ack}, e_m.port != 0 ? 2 : 1);
                chk("err", e_m.port != 0 ? m1_err : m0_err, e_m.err);
                chk("err_other", e_m.port != 0 ? m0_err : m1_err, 0);
                if (!e_m.we) chk("rdata", e_m.port != 0 ? m1_rdata : m0_rdata, e_m.rd);
                chk("ack_cycle", cyc, e_m.cyc);
            end
        end
    end

    // One transfer on port p, expected ack lat cycles after the request is first presented
    task automatic xfer(input int p, input logic [15:0] a, input logic we, input logic [7:0] wd,
                        input logic [7:0] rd, input logic err, input int lat);
        exp_t e;
        bit   got = 0;
        @(posedge clk);
        #1;
        if (p != 0) begin m1_a = a; m1_we = we; m1_wdata = wd; m1_req = 1; end
        else        begin m0_a = a; m0_we = we; m0_wdata = wd; m0_req = 1; end
        e.port = p; e.rd = rd; e.err = err; e.we = we; e.cyc = cyc + lat;
        q.push_back(e);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = p != 0 ? m1_ack : m0_ack;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL xfer_timeout: got no ack on port %0d, expected one", p);
        end
        m0_req = 0;
        m1_req = 0;
    endtask

    initial begin
        int s, n;
        exp_t e;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {sram_cs_ide, sram_cs_cdda, sram_cs_sdcard, sram_oe, sram_we,
                            m0_ack, m1_ack, m0_err, m1_err}, 0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
        chk("rst_addr", {sram_a, sram_d_out}, 0);
        @(negedge clk) reset_ = 1;

        // IDE read, zero wait
        d_from_ide = 8'h5A;
        s = n_ide;
        xfer(0, 16'h1005, 0, 8'h00, 8'h5A, 0, 3);
        chk("ide_cs_cycles", n_ide - s, 1);

        // CDDA write stretched by four wait cycles
        wait_cdda = 1;
        s = n_cdda;
        fork
            xfer(1, 16'h0800, 1, 8'h3C, 8'h00, 0, 7);
            begin
                wait (m1_req);
                repeat (3) @(posedge clk);
                #1;
                chk("wr_cs_cdda", sram_cs_cdda, 1);
                chk("wr_we", {sram_we, sram_oe}, 2'b10);
                chk("wr_dout", sram_d_out, 8'h3C);
                chk("wr_addr", sram_a, 16'h0800);
                repeat (3) @(posedge clk);
                #1 wait_cdda = 0;
            end
        join
        chk("cdda_cs_cycles", n_cdda - s, 5);

        // Both masters requesting continuously: round-robin 0,1,0,1
        d_from_cdda = 8'hC3;
        @(posedge clk);
        #1;
        m0_a = 16'h1005; m0_we = 0; m1_a = 16'h0800; m1_we = 0;
        m0_req = 1; m1_req = 1;
        for (int k = 0; k < 4; k++) begin
            e.port = k % 2; e.rd = (k % 2) != 0 ? 8'hC3 : 8'h5A; e.err = 0; e.we = 0;
            e.cyc = cyc + 3 + 4 * k;
            q.push_back(e);
        end
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (m0_ack | m1_ack) n++;
        end
        m0_req = 0; m1_req = 0;
        chk("rr_acks", n, 4);

        // SD card wait stuck high: timeout, then a normal transfer
        d_from_sdcard = 8'h77;
        wait_sdcard = 1;
        s = n_sd;
        xfer(0, 16'h0000, 0, 8'h00, 8'hFF, 1, 10);
        chk("tmo_cs_cycles", n_sd - s, 8);
        wait_sdcard = 0;
        xfer(0, 16'h0000, 0, 8'h00, 8'h77, 0, 3);

        // Wait on an unselected target must not stretch; high address bits ignored
        wait_ide = 1;
        s = n_ide;
        xfer(1, 16'h2000, 0, 8'h00, 8'h77, 0, 3);
        chk("unsel_ide_cs", n_ide - s, 0);
        wait_ide = 0;

        // Asynchronous reset during ACCESS
        wait_ide = 1;
        @(posedge clk);
        #1;
        m0_a = 16'h1005; m0_we = 0; m0_req = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_cs", sram_cs_ide, 1);
        #2 reset_ = 0;
        #1;
        chk("async_rst", {sram_cs_ide, sram_cs_cdda, sram_cs_sdcard, sram_oe, sram_we,
                          m0_ack, m1_ack, busy}, 0);
        m0_req = 0;
        wait_ide = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_ = 1;
        chk("rst_rdata2", {m0_rdata, m1_rdata}, 0);
        repeat (6) @(posedge clk);
        chk("no_stale_exp", q.size(), 0);
        xfer(0, 16'h1005, 0, 8'h00, 8'h5A, 0, 3);
        repeat (2) @(posedge clk);
        chk("final_queue", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
